// File: rtl/tick_stretch_pkg.sv
// ---------------------------------------------------------------------------
// tick_stretch_pkg
// Shared definitions for the tick stretcher:
//   - state_t : control FSM encoding (IDLE / ON / GAP)
//   - DEFAULT_N  : default phase counter width (2^21 cycles ~ 40 ms at 50 MHz)
//   - DEFAULT_PW : default pending-tick counter width
// ---------------------------------------------------------------------------
package tick_stretch_pkg;

    localparam int DEFAULT_N  = 21;
    localparam int DEFAULT_PW = 3;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        ON   = 2'b01,
        GAP  = 2'b10
    } state_t;

endpackage

// File: rtl/tick_stretch_phase_timer.sv
// ---------------------------------------------------------------------------
// tick_stretch_phase_timer
// N-bit loadable down-counter that times one ON or GAP phase.
// Ports:
//   clk   - system clock, rising edge
//   reset - synchronous active-high reset, clears the count
//   load  - load the counter with all ones (start of a 2^N-cycle phase)
//   dec   - decrement by one; holds at zero, never wraps
//   zero  - high while the count is zero, i.e. the current cycle is the
//           last one of the phase and the next edge ends it
// ---------------------------------------------------------------------------
module tick_stretch_phase_timer
    import tick_stretch_pkg::*;
#(
    parameter int N = DEFAULT_N
) (
    input  logic clk,
    input  logic reset,
    input  logic load,
    input  logic dec,
    output logic zero
);

    logic [N-1:0] count;

    // Load takes priority over decrement; the zero guard keeps the count
    // from wrapping even if dec is held in the last cycle of a phase.
    always_ff @(posedge clk) begin
        if (reset) begin
            count <= '0;
        end else if (load) begin
            count <= '1;
        end else if (dec && (count != '0)) begin
            count <= count - N'(1);
        end
    end

    assign zero = (count == '0);

endmodule

// File: rtl/tick_stretch.sv
// ---------------------------------------------------------------------------
// tick_stretch
// Stretches single-cycle tick strobes into visible LED blinks: each blink is
// 2^N cycles on followed by an enforced 2^N-cycle off gap.
// Ports:
//   clk   - system clock, rising edge
//   reset - synchronous active-high reset; aborts a blink, clears the queue
//   tick  - single-cycle event strobe
//   led   - registered stretched pulse
//   busy  - high whenever the FSM is not IDLE
//   pend  - number of queued ticks still to be shown (PW bits)
//   drop  - one-cycle strobe when a tick is discarded
// Configuration:
//   TICK_STRETCH_QUEUE_EN - when defined, ticks arriving during a blink are
//   queued (saturating at 2^PW-1) and replayed as full blinks; when not
//   defined, such ticks are discarded and pend is tied to zero.
// ---------------------------------------------------------------------------
module tick_stretch
    import tick_stretch_pkg::*;
#(
    parameter int N  = DEFAULT_N,
    parameter int PW = DEFAULT_PW
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          tick,
    output logic          led,
    output logic          busy,
    output logic [PW-1:0] pend,
    output logic          drop
);

    state_t state;
    logic   timer_load;
    logic   timer_dec;
    logic   timer_zero;
    logic   tick_busy;
    logic   replay;
    logic   drop_next;

    tick_stretch_phase_timer #(
        .N(N)
    ) u_phase_timer (
        .clk   (clk),
        .reset (reset),
        .load  (timer_load),
        .dec   (timer_dec),
        .zero  (timer_zero)
    );

    // A tick that lands while a blink is in progress (ON or GAP, including
    // the last GAP cycle) is never allowed to restart the running phase.
    assign tick_busy = tick && (state != IDLE);

`ifdef TICK_STRETCH_QUEUE_EN
    logic [PW-1:0] pend_q;
    logic          gap_end;

    assign gap_end = (state == GAP) && timer_zero;

    // A tick on the last GAP cycle counts as queued, so it also triggers a
    // replay even when the queue was empty.
    assign replay = (pend_q != '0) || tick;

    // At the end of a gap a simultaneous tick and replay cancel out, so the
    // tick can never be lost to saturation there.
    assign drop_next = tick_busy && !gap_end && (pend_q == '1);

    // Pending-tick counter: +1 per tick during a blink, -1 per replay,
    // unchanged when both happen on the same edge, saturating at all ones.
    always_ff @(posedge clk) begin
        if (reset) begin
            pend_q <= '0;
        end else if (gap_end && replay) begin
            if (!tick) begin
                pend_q <= pend_q - PW'(1);
            end
        end else if (tick_busy && (pend_q != '1)) begin
            pend_q <= pend_q + PW'(1);
        end
    end

    assign pend = pend_q;
`else
    assign replay    = 1'b0;
    assign drop_next = tick_busy;
    assign pend      = {PW{1'b0}};
`endif

    // Timer control: every phase starts with a load to all ones and counts
    // down to zero, giving exactly 2^N cycles per phase.
    always_comb begin
        timer_load = 1'b0;
        timer_dec  = 1'b0;
        case (state)
            IDLE: timer_load = tick;
            ON: begin
                if (timer_zero) begin
                    timer_load = 1'b1;
                end else begin
                    timer_dec = 1'b1;
                end
            end
            GAP: begin
                if (timer_zero) begin
                    timer_load = replay;
                end else begin
                    timer_dec = 1'b1;
                end
            end
            default: begin
                timer_load = 1'b0;
                timer_dec  = 1'b0;
            end
        endcase
    end

    // Control FSM with registered led and drop so both are glitch-free.
    // led follows the state being entered, so it rises one cycle after tick.
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
            led   <= 1'b0;
            drop  <= 1'b0;
        end else begin
            drop <= drop_next;
            case (state)
                IDLE: begin
                    if (tick) begin
                        state <= ON;
                        led   <= 1'b1;
                    end
                end
                ON: begin
                    if (timer_zero) begin
                        state <= GAP;
                        led   <= 1'b0;
                    end
                end
                GAP: begin
                    if (timer_zero) begin
                        if (replay) begin
                            state <= ON;
                            led   <= 1'b1;
                        end else begin
                            state <= IDLE;
                        end
                    end
                end
                default: begin
                    state <= IDLE;
                    led   <= 1'b0;
                end
            endcase
        end
    end

    assign busy = (state != IDLE);

endmodule

// File: tb/tb_tick_stretch.sv
// ---------------------------------------------------------------------------
// tb_tick_stretch
// Directed self-checking bench for tick_stretch with N=3 (8-cycle phases)
// and PW=2 (queue saturates at 3). Expected values follow both builds,
// selected by TICK_STRETCH_QUEUE_EN.
// ---------------------------------------------------------------------------
module tb_tick_stretch;

`ifdef TICK_STRETCH_QUEUE_EN
    localparam bit QUEUE = 1'b1;
`else
    localparam bit QUEUE = 1'b0;
`endif

    logic       clk;
    logic       reset;
    logic       tick;
    logic       led;
    logic       busy;
    logic [1:0] pend;
    logic       drop;

    int checks;
    int errors;
    int cyc;

    tick_stretch #(
        .N  (3),
        .PW (2)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .tick  (tick),
        .led   (led),
        .busy  (busy),
        .pend  (pend),
        .drop  (drop)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Single comparison point: counts every check and reports mismatches.
    task automatic check_output(input string tag, input int actual, input int expected);
        checks++;
        if (actual != expected) begin
            errors++;
            $display("[TB] FAIL %s cycle %0d: got %0d expected %0d", tag, cyc, actual, expected);
        end
    endtask

    task automatic check_all(input int e_led, input int e_busy, input int e_pend, input int e_drop);
        check_output("led",  int'(led),  e_led);
        check_output("busy", int'(busy), e_busy);
        check_output("pend", int'(pend), e_pend);
        check_output("drop", int'(drop), e_drop);
    endtask

    // Advance one clock; inputs change and outputs are sampled 1 ns after
    // the rising edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Two reset edges, check the cleared state, then release. The cycle
    // following the return is cycle 0 of the next scenario.
    task automatic apply_reset();
        reset = 1'b1;
        tick  = 1'b0;
        step();
        step();
        cyc = -1;
        check_all(0, 0, 0, 0);
        reset = 1'b0;
    endtask

    // First tick at cycle t0, then n further ticks on cycles t0+1..t0+n,
    // all inside the first ON phase (which spans t0+1..t0+8).
    task automatic apply_stimulus(input int t0, input int n);
        int b;
        int queued;
        int blinks;
        int last;
        int rel;
        int e_led;
        int e_busy;
        int e_pend;
        int e_drop;
        b      = t0 + 1;
        queued = QUEUE ? ((n > 3) ? 3 : n) : 0;
        blinks = 1 + queued;
        last   = b + 16 * blinks + 4;
        for (int c = 0; c <= last; c++) begin
            cyc    = c;
            rel    = c - b;
            e_led  = ((rel >= 0) && ((rel / 16) < blinks) && ((rel % 16) < 8)) ? 1 : 0;
            e_busy = ((rel >= 0) && (rel < 16 * blinks)) ? 1 : 0;
            if (rel < 0) begin
                e_pend = 0;
            end else if (rel < 16) begin
                e_pend = (rel < queued) ? rel : queued;
            end else begin
                e_pend = ((queued - rel / 16) > 0) ? (queued - rel / 16) : 0;
            end
            e_drop = ((rel >= 1) && (rel <= n) && (!QUEUE || (rel > 3))) ? 1 : 0;
            check_all(e_led, e_busy, e_pend, e_drop);
            tick = ((c >= t0) && (c <= t0 + n)) ? 1'b1 : 1'b0;
            step();
        end
        tick = 1'b0;
    endtask

    // Tick on the very last GAP cycle while one tick is already queued.
    task automatic run_last_gap_tick();
        int e_led;
        int e_busy;
        int e_pend;
        int e_drop;
        for (int c = 0; c <= 55; c++) begin
            cyc = c;
            if (QUEUE) begin
                e_led  = (((c >= 2) && (c <= 9)) || ((c >= 18) && (c <= 25)) ||
                          ((c >= 34) && (c <= 41))) ? 1 : 0;
                e_busy = ((c >= 2) && (c <= 49)) ? 1 : 0;
                e_pend = ((c >= 4) && (c <= 33)) ? 1 : 0;
                e_drop = 0;
            end else begin
                e_led  = ((c >= 2) && (c <= 9)) ? 1 : 0;
                e_busy = ((c >= 2) && (c <= 17)) ? 1 : 0;
                e_pend = 0;
                e_drop = ((c == 4) || (c == 18)) ? 1 : 0;
            end
            check_all(e_led, e_busy, e_pend, e_drop);
            tick = ((c == 1) || (c == 3) || (c == 17)) ? 1'b1 : 1'b0;
            step();
        end
        tick = 1'b0;
    endtask

    // Reset during the third ON cycle with two ticks queued; a tick held
    // together with reset must be ignored.
    task automatic run_mid_blink_reset();
        int e_led;
        int e_busy;
        int e_pend;
        int e_drop;
        for (int c = 0; c <= 30; c++) begin
            cyc = c;
            if (c <= 4) begin
                e_led  = (c >= 2) ? 1 : 0;
                e_busy = (c >= 2) ? 1 : 0;
                e_pend = !QUEUE ? 0 : (c == 3) ? 1 : (c == 4) ? 2 : 0;
                e_drop = (!QUEUE && ((c == 3) || (c == 4))) ? 1 : 0;
            end else begin
                e_led  = 0;
                e_busy = 0;
                e_pend = 0;
                e_drop = 0;
            end
            check_all(e_led, e_busy, e_pend, e_drop);
            tick  = ((c >= 1) && (c <= 4)) ? 1'b1 : 1'b0;
            reset = (c == 4) ? 1'b1 : 1'b0;
            step();
        end
        tick  = 1'b0;
        reset = 1'b0;
    endtask

    initial begin
        checks = 0;
        errors = 0;
        cyc    = 0;
        reset  = 1'b1;
        tick   = 1'b0;

        $display("[TB] single tick at cycle 5");
        apply_reset();
        apply_stimulus(5, 0);

        $display("[TB] one extra tick during ON");
        apply_reset();
        apply_stimulus(1, 1);

        $display("[TB] three extra ticks during ON");
        apply_reset();
        apply_stimulus(1, 3);

        $display("[TB] five extra ticks during ON");
        apply_reset();
        apply_stimulus(1, 5);

        $display("[TB] tick on last GAP cycle");
        apply_reset();
        run_last_gap_tick();

        $display("[TB] reset mid-blink");
        apply_reset();
        run_mid_blink_reset();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/tick_stretch.md
TICK_STRETCH -- requirements
Module: tick_stretch

Interface
REQ-001 The module SHALL provide parameter N, default 21, counter width; each phase lasts 2^N clk cycles (about 40 ms at 50 MHz).
REQ-002 The module SHALL provide parameter PW, default 3, pending-tick counter width.
REQ-003 The module SHALL have port clk, input, 1 bit, the single system clock; all logic is on its rising edge.
REQ-004 The module SHALL have port reset, input, 1 bit, synchronous active-high reset.
REQ-005 The module SHALL have port tick, input, 1 bit, a single-cycle event strobe (for example, a debounced press tick).
REQ-006 The module SHALL have port led, output, 1 bit, the stretched visible pulse.
REQ-007 The module SHALL have port busy, output, 1 bit, high in any state other than IDLE.
REQ-008 The module SHALL have port pend, output, PW bits, the count of queued ticks not yet shown.
REQ-009 The module SHALL have port drop, output, 1 bit, a one-cycle strobe when a tick is discarded.

Function
REQ-010 The state machine SHALL have exactly three states:
- IDLE: led=0.
- ON: led=1.
- GAP: led=0, enforced off-time between blinks.
REQ-011 In IDLE, tick=1 SHALL cause the following on the next edge:
- go to ON;
- load the phase counter with all ones;
- led rises exactly 1 cycle after tick.
REQ-012 In ON and GAP, the counter SHALL decrement each cycle, so each phase lasts exactly 2^N cycles.
REQ-013 At the end of ON (counter reaches 0), the state SHALL move to GAP and reload the counter with all ones.
REQ-014 At the end of GAP, the state SHALL go to ON with counter reload and pend-1 if pend>0; otherwise it SHALL go to IDLE.
REQ-015 A tick arriving during ON or GAP SHALL be handled per the Configuration section, never restarting or extending the current phase.
REQ-016 Simultaneous tick and pend decrement at the GAP end SHALL leave pend unchanged (net zero).
REQ-017 pend SHALL saturate at 2^PW-1; a tick arriving at saturation SHALL leave pend unchanged and assert drop for that cycle.
REQ-018 A tick arriving in the same cycle that IDLE is entered SHALL be treated as arriving in GAP: queued, or dropped per the Configuration section.
REQ-019 The counter SHALL be exactly N bits and SHALL never wrap below zero; decrement happens only in ON and GAP.
REQ-020 busy SHALL equal (state != IDLE), decoded combinationally from the state register.

Reset
REQ-021 On reset=1 at a clock edge, the module SHALL set: state=IDLE, counter=0, pend=0, led=0, drop=0, busy=0.
REQ-022 Reset mid-blink SHALL abort the blink immediately and discard all pending ticks; tick is ignored while reset=1.
REQ-023 led SHALL be a registered output, glitch-free.

Configuration
REQ-024 With macro TICK_STRETCH_QUEUE_EN defined:
- ticks during ON or GAP increment pend per REQ-017;
- each queued tick replays as a full ON+GAP sequence.
REQ-025 Without TICK_STRETCH_QUEUE_EN:
- pend is tied to 0;
- every tick during ON or GAP is discarded and pulses drop;
- the PW-bit register is not built.

Structure
REQ-026 A shared package SHALL hold the state encoding constants IDLE=2'b00, ON=2'b01, GAP=2'b10, plus the default N.
REQ-027 The design SHALL have one natural sub-module, phase_timer: an N-bit loadable down-counter with load, dec and zero-next outputs.
REQ-028 The control FSM and pend logic SHALL stay in tick_stretch; the RTL SHALL be 120-400 lines total.

Verification
All scenarios use N=3 (8-cycle phases) and PW=2.
REQ-029 Reset release, then tick at cycle 5 -> led=1 over cycles 6..13 and 0 over 14..21; busy falls at cycle 22; pend=0 throughout.
REQ-030 QUEUE_EN: three ticks during the first ON -> pend reaches 3; four blinks total, each 8 on / 8 off; pend counts 3,2,1,0.
REQ-031 QUEUE_EN: five ticks during the first ON -> pend saturates at 3; the fourth and fifth queued ticks each pulse drop for one cycle.
REQ-032 Tick exactly on the last GAP cycle with pend=1 -> next ON starts, pend stays 1, and one further blink follows.
REQ-033 Without QUEUE_EN: tick during ON -> drop=1 for one cycle, pend=0, only one blink.
REQ-034 Reset asserted at cycle 3 of ON with pend=2 -> next cycle led=0, busy=0, pend=0, and no further blinks.
